// File: rtl/immgen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : immgen_pipe                                                  |
// | Description : Elastic RV32/RV64 immediate generator. Decodes the I, S, B,  |
// |               U, J and shift-amount immediate forms from a 32-bit          |
// |               instruction word, sign-extends to XLEN, and buffers the      |
// |               result in a 2-entry valid/ready queue for the execute-stage  |
// |               operand mux.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   XLEN        : output width, 32 or 64                                     |
// |   AUTO_DECODE : 1 = format from instr[6:0] (sel ignored), 0 = use sel      |
// | Ports                                                                      |
// |   clk         : rising-edge clock                                          |
// |   reset       : synchronous active-high reset, overrides all handshakes    |
// |   in_valid    : instr/sel present                                          |
// |   in_ready    : queue can accept this cycle (low during reset)             |
// |   instr       : instruction word                                           |
// |   sel         : 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 11x illegal  |
// |   out_valid   : head entry valid                                           |
// |   out_ready   : consumer takes the head entry this cycle                   |
// |   immout      : head immediate (0 when queue empty)                        |
// |   illegal     : head entry had an unsupported format/opcode                |
// +----------------------------------------------------------------------------+
module immgen_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immout,
    output logic            illegal
);

    // Format codes shared by the sel input and the auto decoder
    localparam logic [2:0] c_fmt_i     = 3'b000;
    localparam logic [2:0] c_fmt_s     = 3'b001;
    localparam logic [2:0] c_fmt_b     = 3'b010;
    localparam logic [2:0] c_fmt_u     = 3'b011;
    localparam logic [2:0] c_fmt_j     = 3'b100;
    localparam logic [2:0] c_fmt_shamt = 3'b101;
    localparam logic [2:0] c_fmt_ill   = 3'b110;

    // Major opcodes recognised in auto mode
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // RV64 shifts use a 6-bit shamt, RV32 only 5 bits (instr[25] ignored)
    localparam logic [31:0] c_shamt_mask = (XLEN == 64) ? 32'h0000_003F : 32'h0000_001F;

    localparam logic [1:0] c_count_full = 2'd2;

    // ------------------------------------------------------------------
    // Format selection
    // ------------------------------------------------------------------
    logic [2:0] w_fmt;

    generate
        if (AUTO_DECODE) begin : g_auto_fmt
            logic w_unused_sel;
            assign w_unused_sel = ^sel;

            always_comb begin
                w_fmt = c_fmt_ill;
                case (instr[6:0])
                    // OP-IMM: funct3 001 (slli) and 101 (srli/srai) share
                    // instr[13:12]==01 and carry a shift amount instead
                    c_op_imm:    w_fmt = (instr[13:12] == 2'b01) ? c_fmt_shamt : c_fmt_i;
                    c_op_load:   w_fmt = c_fmt_i;
                    c_op_jalr:   w_fmt = c_fmt_i;
                    c_op_store:  w_fmt = c_fmt_s;
                    c_op_branch: w_fmt = c_fmt_b;
                    c_op_lui:    w_fmt = c_fmt_u;
                    c_op_auipc:  w_fmt = c_fmt_u;
                    c_op_jal:    w_fmt = c_fmt_j;
                    default:     w_fmt = c_fmt_ill;
                endcase
            end
        end else begin : g_sel_fmt
            logic w_unused_opcode;
            assign w_unused_opcode = ^instr[6:0];
            assign w_fmt = sel;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Immediate decode, built at 32 bits then sign-extended to XLEN.
    // SHAMT has bit 31 clear, so sign extension leaves it zero-extended.
    // ------------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic            w_ill;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_imm32 = '0;
        w_ill   = 1'b0;
        case (w_fmt)
            c_fmt_i:     w_imm32 = {{20{instr[31]}}, instr[31:20]};
            c_fmt_s:     w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            c_fmt_b:     w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            c_fmt_u:     w_imm32 = {instr[31:12], 12'b0};
            c_fmt_j:     w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0};
            c_fmt_shamt: w_imm32 = {26'b0, instr[25:20]} & c_shamt_mask;
            default: begin
                w_imm32 = '0;
                w_ill   = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_ext64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_ext32
            assign w_imm = w_imm32;
        end
    endgenerate

    // ------------------------------------------------------------------
    // 2-entry circular output queue
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_imm [2];
    logic            r_ill [2];
    logic            r_wr;
    logic            r_rd;
    logic [1:0]      r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is not reset; the count gates it away from the outputs.
    // No push can occur during reset because in_ready is held low then.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm[r_wr] <= w_imm;
            r_ill[r_wr] <= w_ill;
        end
    end

    assign in_ready  = (r_count != c_count_full) && !reset;
    assign out_valid = (r_count != 2'd0);
    assign immout    = out_valid ? r_imm[r_rd] : '0;
    assign illegal   = out_valid ? r_ill[r_rd] : 1'b0;

endmodule
`default_nettype wire
